elevator_call_scheduler: RTL

- Car controller for the 5-stop elevator (G, 1-4).
- Latches floor calls and schedules car motion with SCAN: keep direction while calls exist ahead, otherwise reverse.
- Sequences the door open/dwell/close cycle and drives the up/down/open/close signals consumed by the elevator top level.
- Sits between the button inputs (inG..in4, inopen, inclose) and the car/door actuators.

---
 rtl/elevator_pkg.sv | 43 ++++
 rtl/elevator_call_scheduler_door_timer.sv | 35 +++
 rtl/elevator_call_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared state/direction types and SCAN look-ahead helpers for the elevator car controller.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS_DEF = 5;
  localparam int unsigned FLOOR_W        = $clog2(NUM_FLOORS_DEF);
  localparam int unsigned MAX_FLOORS     = 16;
  localparam int unsigned MAX_FLOOR_W    = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR_OPEN = 3'd3,
    CLOSING   = 3'd4
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Callers zero-extend their pending vector and floor to the widest supported building.
  function automatic logic calls_above(input logic [MAX_FLOORS-1:0]  pend,
                                       input logic [MAX_FLOOR_W-1:0] floor);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(MAX_FLOORS); i++) begin
      if (i > int'(floor) && pend[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic calls_below(input logic [MAX_FLOORS-1:0]  pend,
                                       input logic [MAX_FLOOR_W-1:0] floor);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(MAX_FLOORS); i++) begin
      if (i < int'(floor) && pend[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/elevator_call_scheduler_door_timer.sv
// Door dwell down-counter: load on door entry, reload on re-request, force-expire on close.
module elevator_door_timer #(
  parameter int unsigned DOOR_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic reload_i,
  input  logic force_i,
  input  logic hold_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(DOOR_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A reload always wins; a close request expires the dwell in the same cycle it is seen.
  assign expired_o = !reload_i && (force_i || cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (hold_i)                cnt_d = cnt_q;
    else if (load_i)           cnt_d = CW'(DOOR_CYCLES - 1);
    else if (reload_i)         cnt_d = CW'(DOOR_CYCLES);
    else if (force_i)          cnt_d = '0;
    else if (cnt_q != '0)      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN car controller: latches floor calls, moves the car and sequences the door.
// Optional emergency stop freeze is built when ELEV_ESTOP_EN is defined.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = NUM_FLOORS_DEF,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef ELEV_ESTOP_EN
  input  logic                          estop,
`endif
  input  logic [NUM_FLOORS-1:0]         call_req,
  input  logic                          door_open_req,
  input  logic                          door_close_req,
  output logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
  output logic [NUM_FLOORS-1:0]         pending,
  output logic                          up,
  output logic                          down,
  output logic                          open,
  output logic                          close,
  output logic                          idle
);

  localparam int unsigned FW = $clog2(NUM_FLOORS);
  localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);

  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d;
  logic [FW-1:0]         cur_floor_q, floor_d;
  logic [TW-1:0]         travel_q, travel_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, pend_now;
  logic                  up_q, down_q, open_q, idle_q;

  logic door_load, door_reload, door_force, door_expired;
  logic halt;
  logic above_here, below_here, ahead_next;

`ifdef ELEV_ESTOP_EN
  assign halt = estop;
`else
  assign halt = 1'b0;
`endif

  assign pend_now   = pending_q | call_req;
  assign above_here = calls_above(MAX_FLOORS'(pending_q), MAX_FLOOR_W'(cur_floor_q));
  assign below_here = calls_below(MAX_FLOORS'(pending_q), MAX_FLOOR_W'(cur_floor_q));

  elevator_door_timer #(
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_door_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (door_load),
    .reload_i (door_reload),
    .force_i  (door_force),
    .hold_i   (halt),
    .expired_o(door_expired)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    floor_d     = cur_floor_q;
    travel_d    = travel_q;
    door_reload = 1'b0;
    door_force  = 1'b0;
    ahead_next  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pending_q[cur_floor_q] || door_open_req)   state_d = DOOR_OPEN;
        else if (dir_q == DIR_UP && above_here)        state_d = MOVE_UP;
        else if (dir_q == DIR_DOWN && below_here)      state_d = MOVE_DOWN;
        else if (above_here) begin
          dir_d   = DIR_UP;
          state_d = MOVE_UP;
        end else if (below_here) begin
          dir_d   = DIR_DOWN;
          state_d = MOVE_DOWN;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (travel_q == TW'(TRAVEL_CYCLES - 1)) begin
          travel_d = '0;
          floor_d  = (state_q == MOVE_UP) ? cur_floor_q + FW'(1) : cur_floor_q - FW'(1);
          ahead_next = (state_q == MOVE_UP)
                     ? calls_above(MAX_FLOORS'(pending_q), MAX_FLOOR_W'(floor_d))
                     : calls_below(MAX_FLOORS'(pending_q), MAX_FLOOR_W'(floor_d));
          // A call landing on the arrival cycle still stops the car there.
          if (pend_now[floor_d])  state_d = DOOR_OPEN;
          else if (!ahead_next)   state_d = IDLE;
        end else begin
          travel_d = travel_q + TW'(1);
        end
      end

      DOOR_OPEN: begin
        door_reload = door_open_req || call_req[cur_floor_q];
        door_force  = door_close_req;
        if (door_expired) state_d = CLOSING;
      end

      CLOSING: begin
        if (door_open_req || pending_q[cur_floor_q]) state_d = DOOR_OPEN;
        else                                         state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef ELEV_ESTOP_EN
    if (estop) begin
      state_d     = state_q;
      dir_d       = dir_q;
      floor_d     = cur_floor_q;
      travel_d    = travel_q;
      door_reload = 1'b0;
      door_force  = 1'b0;
    end
`endif

    door_load = (state_d == DOOR_OPEN) && (state_q != DOOR_OPEN);

    // The served floor's call is dropped while the door is (or becomes) open there.
    pending_d = pend_now;
    if (state_d == DOOR_OPEN) pending_d[floor_d] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= DIR_UP;
      cur_floor_q <= '0;
      travel_q    <= '0;
      pending_q   <= '0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      open_q      <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cur_floor_q <= floor_d;
      travel_q    <= travel_d;
      pending_q   <= pending_d;
      up_q        <= (state_d == MOVE_UP) && !halt;
      down_q      <= (state_d == MOVE_DOWN) && !halt;
      open_q      <= (state_d == DOOR_OPEN);
      idle_q      <= (state_d == IDLE) && (pending_d == '0);
    end
  end

  assign cur_floor = cur_floor_q;
  assign pending   = pending_q;
  assign up        = up_q;
  assign down      = down_q;
  assign open      = open_q;
  assign close     = ~open_q;
  assign idle      = idle_q;

endmodule
